// File: rtl/uart_pkg.sv
// Shared constants and types for the UART loopback path.
// Holds the byte width, bit timing and the drain state machine encoding.
package uart_pkg;

    localparam int BYTE_W       = 8;
    localparam int CLKS_PER_BIT = 217;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count and full/empty flags.
// Pointers wrap naturally; the count is kept separately so full and empty are unambiguous.
module sync_fifo #(
    parameter int  DEPTH = 16,
    parameter int  W     = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Clear,
    input  logic          i_Push,
    input  logic [W-1:0]  i_Data,
    input  logic          i_Pop,
    output logic [W-1:0]  o_Data,
    output logic [CW-1:0] o_Count,
    output logic          o_Empty,
    output logic          o_Full
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
    assign pop_ok  = i_Pop && !empty_q && !i_Clear;
    assign push_ok = i_Push && (!full_q || pop_ok) && !i_Clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_Clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage carries no reset; contents are only observable through a valid pointer range.
    always_ff @(posedge i_Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_Data;
    end

    assign o_Data  = mem_q[rd_ptr_q];
    assign o_Count = count_q;
    assign o_Empty = empty_q;
    assign o_Full  = full_q;

endmodule

// File: rtl/uart_loop_buffer.sv
// Loopback byte buffer: queues received bytes and drains them one at a time into the
// transmitter using its active/done handshake. Count, empty, full and overflow feed debug displays.
module uart_loop_buffer
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Clear,
    input  logic              i_RX_DV,
    input  logic [BYTE_W-1:0] i_RX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done,
    output logic              o_TX_DV,
    output logic [BYTE_W-1:0] o_TX_Byte,
    output logic [CW-1:0]     o_Count,
    output logic              o_Empty,
    output logic              o_Full,
    output logic              o_Overflow,
    output drain_state_t      o_State
);

    // Handshake: o_TX_DV is a single-cycle launch; the transmitter answers with i_TX_Active
    // while busy and a single-cycle i_TX_Done; exactly one byte is outstanding at a time.

    drain_state_t      state_q, state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              overflow_q, overflow_d;

    logic              fifo_pop;
    logic              fifo_push;
    logic [BYTE_W-1:0] fifo_data;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clear (i_Clear),
        .i_Push  (fifo_push),
        .i_Data  (i_RX_Byte),
        .i_Pop   (fifo_pop),
        .o_Data  (fifo_data),
        .o_Count (fifo_count),
        .o_Empty (fifo_empty),
        .o_Full  (fifo_full)
    );

    assign fifo_push = i_RX_DV && !i_Clear;

    always_comb begin
        state_d    = state_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        overflow_d = overflow_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                // A clear cycle launches nothing so a flushed byte is never sent.
                if (!fifo_empty && !i_TX_Active && !i_Clear) begin
                    fifo_pop  = 1'b1;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = fifo_data;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_TX_Done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_Clear) begin
            overflow_d = 1'b0;
        end else if (i_RX_DV && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_TX_DV    = tx_dv_q;
    assign o_TX_Byte  = tx_byte_q;
    assign o_Count    = fifo_count;
    assign o_Empty    = fifo_empty;
    assign o_Full     = fifo_full;
    assign o_Overflow = overflow_q;
    assign o_State    = state_q;

endmodule

// File: tb/tb_uart_loop_buffer.sv
// Bench for uart_loop_buffer: vector table, directed corner sequences and random traffic,
// all checked against a queue-based model of the buffer plus a simple transmitter model.
module tb_uart_loop_buffer;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_Clk = 1'b0;
    logic          i_Rst_L;
    logic          i_Clear;
    logic          i_RX_DV;
    logic [7:0]    i_RX_Byte;
    logic          i_TX_Active;
    logic          i_TX_Done;
    logic          o_TX_DV;
    logic [7:0]    o_TX_Byte;
    logic [CW-1:0] o_Count;
    logic          o_Empty;
    logic          o_Full;
    logic          o_Overflow;
    drain_state_t  o_State;

    uart_loop_buffer #(.DEPTH(DEPTH)) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Clear     (i_Clear),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .o_Count     (o_Count),
        .o_Empty     (o_Empty),
        .o_Full      (o_Full),
        .o_Overflow  (o_Overflow),
        .o_State     (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    bit         m_busy = 0;
    bit         m_ovf  = 0;
    bit         m_dv   = 0;
    logic [7:0] m_byte = 8'h00;
    bit         saw_full = 0;

    // Transmitter model
    int tx_len  = 10;
    int tx_cnt  = 0;
    bit tx_busy = 0;
    bit tx_hold = 0;

    typedef struct {
        logic          rx_dv;
        logic [7:0]    rx_byte;
        logic          clear;
        logic [CW-1:0] count;
        logic          empty;
        logic          dv;
        logic [7:0]    tx_byte;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_active();
        i_TX_Active = tx_busy || tx_hold;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy = 0;
        m_ovf  = 0;
        m_dv   = 0;
        m_byte = 8'h00;
    endtask

    // One clock: predict from the inputs in force, clock, compare, then advance the transmitter.
    task automatic step();
        bit pop;
        pop  = !m_busy && (exp_q.size() > 0) && !i_TX_Active && !i_Clear;
        m_dv = 0;
        if (i_Clear) begin
            exp_q.delete();
            m_ovf = 0;
        end else begin
            if (pop) begin
                m_byte = exp_q.pop_front();
                m_dv   = 1;
            end
            if (i_RX_DV) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(i_RX_Byte);
                else m_ovf = 1;
            end
        end
        if (m_busy && i_TX_Done) m_busy = 0;
        if (pop) m_busy = 1;

        @(posedge i_Clk);
        #1;
        chk("count",    32'(o_Count),    32'(exp_q.size()));
        chk("empty",    32'(o_Empty),    32'(exp_q.size() == 0));
        chk("full",     32'(o_Full),     32'(exp_q.size() == DEPTH));
        chk("overflow", 32'(o_Overflow), 32'(m_ovf));
        chk("tx_dv",    32'(o_TX_DV),    32'(m_dv));
        chk("tx_byte",  32'(o_TX_Byte),  32'(m_byte));
        chk("state",    32'(o_State),    32'(m_busy ? WAIT_DONE : IDLE));
        if (o_TX_DV) sent_q.push_back(o_TX_Byte);
        if (o_Full) saw_full = 1;

        i_TX_Done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_busy   = 0;
                i_TX_Done = 1'b1;
            end
        end
        if (o_TX_DV) begin
            tx_busy = 1;
            tx_cnt  = tx_len;
        end
        set_active();
    endtask

    task automatic push_byte(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        step();
        i_RX_DV   = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || m_busy || tx_busy) && n < max_cycles) begin
            step();
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n < max_cycles), 32'd1);
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_count"},    32'(o_Count),    32'd0);
        chk({name, "_empty"},    32'(o_Empty),    32'd1);
        chk({name, "_full"},     32'(o_Full),     32'd0);
        chk({name, "_overflow"}, 32'(o_Overflow), 32'd0);
        chk({name, "_tx_dv"},    32'(o_TX_DV),    32'd0);
        chk({name, "_tx_byte"},  32'(o_TX_Byte),  32'h00);
        chk({name, "_state"},    32'(o_State),    32'(IDLE));
    endtask

    initial begin
        bit found_ee;
        int n;

        i_Rst_L     = 1'b0;
        i_Clear     = 1'b0;
        i_RX_DV     = 1'b0;
        i_RX_Byte   = 8'h00;
        i_TX_Active = 1'b0;
        i_TX_Done   = 1'b0;

        // Power-on reset
        repeat (2) @(posedge i_Clk);
        #1;
        check_reset_values("por");
        i_Rst_L = 1'b1;

        // Vector table: single byte launch, queued bytes, clear with a push in the same cycle
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
        vecs[4] = '{1'b1, 8'hC3, 1'b0, 5'd2, 1'b0, 1'b0, 8'hA5};
        vecs[5] = '{1'b1, 8'h99, 1'b1, 5'd0, 1'b1, 1'b0, 8'hA5};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5};
        tx_len = 50;
        sent_q.delete();
        for (int i = 0; i < 7; i++) begin
            i_RX_DV   = vecs[i].rx_dv;
            i_RX_Byte = vecs[i].rx_byte;
            i_Clear   = vecs[i].clear;
            step();
            chk($sformatf("vec%0d_count", i),   32'(o_Count),   32'(vecs[i].count));
            chk($sformatf("vec%0d_empty", i),   32'(o_Empty),   32'(vecs[i].empty));
            chk($sformatf("vec%0d_tx_dv", i),   32'(o_TX_DV),   32'(vecs[i].dv));
            chk($sformatf("vec%0d_tx_byte", i), 32'(o_TX_Byte), 32'(vecs[i].tx_byte));
        end
        i_RX_DV = 1'b0;
        i_Clear = 1'b0;
        drain("vec", 200);
        repeat (5) step();
        chk("vec_sent_count", 32'(sent_q.size()), 32'd1);
        chk("vec_sent_byte",  32'(sent_q[0]),     32'hA5);

        // Burst 00..0F against a slow transmitter held busy while it arrives
        sent_q.delete();
        saw_full = 0;
        tx_len   = 2170;
        tx_hold  = 1;
        set_active();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        tx_hold = 0;
        set_active();
        n = 0;
        while (sent_q.size() < 16 && n < 40000) begin
            step();
            n++;
        end
        chk("burst_sent_count", 32'(sent_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < sent_q.size(); i++)
            chk($sformatf("burst_order%0d", i), 32'(sent_q[i]), 32'(i));
        chk("burst_saw_full", 32'(saw_full),   32'd1);
        chk("burst_overflow", 32'(o_Overflow), 32'd0);
        drain("burst", 3000);

        // Overflow: full FIFO with the transmitter busy drops 8'hEE
        sent_q.delete();
        tx_len  = 20;
        tx_hold = 1;
        set_active();
        for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(0, 8'hED)));
        push_byte(8'hEE);
        chk("ovf_flag",  32'(o_Overflow), 32'd1);
        chk("ovf_count", 32'(o_Count),    32'd16);
        step();
        tx_hold = 0;
        set_active();
        drain("ovf", 2000);
        found_ee = 0;
        foreach (sent_q[i]) if (sent_q[i] == 8'hEE) found_ee = 1;
        chk("ovf_ee_not_sent",   32'(found_ee),      32'd0);
        chk("ovf_sent_count",    32'(sent_q.size()), 32'd16);
        chk("ovf_sticky",        32'(o_Overflow),    32'd1);
        i_Clear = 1'b1;
        step();
        i_Clear = 1'b0;
        chk("ovf_cleared", 32'(o_Overflow), 32'd0);

        // Full FIFO: push 8'h77 in the same cycle as a pop
        sent_q.delete();
        tx_hold = 1;
        set_active();
        for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(0, 8'h76)));
        tx_hold = 0;
        set_active();
        push_byte(8'h77);
        chk("fullpop_count",    32'(o_Count),    32'd16);
        chk("fullpop_overflow", 32'(o_Overflow), 32'd0);
        chk("fullpop_launch",   32'(o_TX_DV),    32'd1);
        drain("fullpop", 2000);
        chk("fullpop_sent_count", 32'(sent_q.size()), 32'd17);
        chk("fullpop_last", 32'(sent_q[sent_q.size()-1]), 32'h77);

        // Clear while waiting for done with 5 bytes queued
        sent_q.delete();
        tx_len = 100;
        for (int i = 0; i < 6; i++) push_byte(8'h40 + 8'(i));
        chk("clrwait_state", 32'(o_State), 32'(WAIT_DONE));
        chk("clrwait_count", 32'(o_Count), 32'd5);
        i_Clear = 1'b1;
        step();
        i_Clear = 1'b0;
        chk("clrwait_count0",   32'(o_Count),    32'd0);
        chk("clrwait_overflow", 32'(o_Overflow), 32'd0);
        chk("clrwait_still_waiting", 32'(o_State), 32'(WAIT_DONE));
        repeat (120) step();
        chk("clrwait_sent_count", 32'(sent_q.size()), 32'd1);

        // Asynchronous reset mid-burst, then a fresh byte
        tx_len = 30;
        for (int i = 0; i < 10; i++) push_byte(8'($urandom_range(0, 255)));
        #2;
        i_Rst_L = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge i_Clk);
        #1;
        check_reset_values("rst_held");
        i_Rst_L = 1'b1;
        sent_q.delete();
        push_byte(8'h5A);
        drain("post_rst", 500);
        chk("post_rst_sent_count", 32'(sent_q.size()), 32'd1);
        chk("post_rst_byte",       32'(sent_q[0]),     32'h5A);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            i_RX_DV   = ($urandom_range(0, 99) < 40);
            i_RX_Byte = 8'($urandom_range(0, 255));
            i_Clear   = ($urandom_range(0, 199) == 0);
            tx_len    = $urandom_range(1, 12);
            if ($urandom_range(0, 49) == 0) tx_hold = ~tx_hold;
            set_active();
            step();
        end
        i_RX_DV = 1'b0;
        i_Clear = 1'b0;
        tx_hold = 0;
        set_active();
        drain("random", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_loop_buffer.md
# uart_loop_buffer

Byte buffer between the UART receiver and the UART transmitter in the loopback path. Received bytes are pushed into a FIFO on each receive-valid pulse. A drain state machine launches them one at a time into the transmitter, using its active/done handshake, so that bursts arriving faster than the transmitter can send are not lost. The occupancy and overflow outputs are available for the 7-segment or LED debug displays.

## Interface
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1: width of the occupancy count; derived, do not override.
- i_Clk  in  1  system clock (25 MHz on the board).
- i_Rst_L  in  1  reset; one clock, reset is asynchronous and active-low.
- i_Clear  in  1  synchronous flush of FIFO contents and the overflow flag.
- i_RX_DV  in  1  one-cycle pulse: i_RX_Byte is valid, push it.
- i_RX_Byte  in  8  received byte.
- i_TX_Active  in  1  transmitter busy.
- i_TX_Done  in  1  one-cycle pulse: transmitter finished its stop bit.
- o_TX_DV  out  1  one-cycle launch pulse to the transmitter.
- o_TX_Byte  out  8  byte to transmit; holds its value from launch until the next launch.
- o_Count  out  CW  current FIFO occupancy, 0..DEPTH.
- o_Empty  out  1  o_Count == 0.
- o_Full  out  1  o_Count == DEPTH.
- o_Overflow  out  1  sticky: a push was dropped.

## Operation
- Reset values: FIFO empty, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_TX_DV=0, o_TX_Byte=8'h00, FSM=IDLE, pointers=0.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy is a separate CW-bit counter.
- Push: on i_RX_DV when not full, or when full and a pop happens in the same cycle.
- Dropped push: i_RX_DV while full with no pop in that cycle. The byte is discarded and o_Overflow is set. Count and contents are unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance. There is no empty-bypass; a push into an empty FIFO is not poppable in the same cycle.
- Drain FSM:
  - IDLE: when !o_Empty and !i_TX_Active, pop the head into o_TX_Byte, pulse o_TX_DV, and go to WAIT_DONE.
  - WAIT_DONE: o_TX_DV=0. On i_TX_Done, go to IDLE.
- Only one byte is ever outstanding. The FSM never issues o_TX_DV while in WAIT_DONE.
- i_Clear takes priority over push and pop in the same cycle:
  - Pointers and count go to 0 and o_Overflow goes to 0.
  - A push in the clear cycle is ignored.
  - FSM state is unaffected; a byte already launched is still awaited in WAIT_DONE.
- Reset asserted mid-operation: everything returns to its reset value immediately. The in-flight transmission is abandoned by this block. After reset, the FSM waits in IDLE until i_TX_Active is low before it launches.
- Count arithmetic: +1 on push only, -1 on pop only, never beyond 0..DEPTH.

## Timing
- All state is registered on the rising edge of i_Clk. Flags and count are registered, not combinational from the pointers.
- Push sampled at edge E0: o_Count and o_Empty update after E0.
- Empty FIFO, FSM in IDLE, transmitter idle: push at E0, pop at E1. o_TX_DV is high and o_TX_Byte is valid for exactly the cycle following E1.
- i_TX_Done sampled at edge Ed: FSM is in IDLE after Ed. The next launch can occur at Ed+1 (back-to-back gap of one cycle).
- o_Full and o_Overflow are visible the cycle after the causing edge.

## Structure
- Shared package uart_pkg:
  - FSM state enum (IDLE, WAIT_DONE).
  - Byte width constant (8).
  - CLKS_PER_BIT constant (217), for the top level and bench.
- One sub-module: sync_fifo.
  - Contents: storage, pointers, count, full/empty flags, clear.
  - The drain FSM and overflow flag live in uart_loop_buffer.

## Test plan
- Single byte 8'hA5 into an idle system -> o_TX_DV high exactly one cycle, 2 edges after the push, with o_TX_Byte=8'hA5; o_Count returns to 0.
- Burst of 16 bytes 8'h00..8'h0F, one per cycle, with the transmitter model busy 2170 cycles per byte -> bytes launched in order 00..0F, o_Full seen, o_Overflow stays 0.
- With DEPTH=16 full and the transmitter held busy, push 8'hEE -> o_Overflow=1, o_Count stays 16, 8'hEE is never transmitted.
- Full FIFO: push 8'h77 in the same cycle as a pop -> o_Count stays 16, no overflow, 8'h77 is transmitted last.
- i_Clear while in WAIT_DONE with 5 bytes queued -> count 0, overflow 0, no further o_TX_DV after i_TX_Done.
- i_Rst_L pulsed low mid-burst, asynchronously between edges -> all outputs at reset values before the next edge; a fresh byte after reset release transmits normally.
